wb_host_port: RTL
=================

Name: wb_host_port

Overview:
- 8-bit strobed register port, tube-parasite style, that acts as a 32-bit Wishbone master.
- Lets an 8-bit initiator (host debug link or 6502-side bridge) read and write any Wishbone slave behind wb_switch: bootrom, wb_sram32, wb_tube.
- Byte-wide accesses only, auto-incrementing address, read prefetch, bus timeout.
- Attaches to the switch as a second master (via arbiter), mirroring wb_tube in the opposite direction.

Parameters:
TIMEOUT, 255, cycles with wb_cyc_o high before forced termination (1..65535)
INC_RST, 1, reset value of CTRL.inc

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
h_addr  in  3  register select
h_din  in  8  write data
h_dout  out  8  read data, combinational from h_addr and register state
h_rd  in  1  one-cycle read strobe; side effects happen on this cycle
h_wr  in  1  one-cycle write strobe
h_busy  out  1  Wishbone transaction in flight
wb_adr_o  out  32  word-aligned address, [1:0]=0
wb_sel_o  out  4  one-hot byte lane
wb_dat_o  out  32  write byte replicated to all four lanes
wb_dat_i  in  32  read data
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe, always equal to wb_cyc_o
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  bus error

Behaviour:
Register map:
- 0–3 ADDR byte 0–3: R/W.
- 4 DATA: write → WB byte write; read → returns RDBUF, then launches prefetch read.
- 5 CTRL: bit0 inc (R/W). Write bit7=1 → launch WB read at ADDR. Write bit6=1 → clear sticky status. Bits 7/6 read 0.
- 6 STATUS: read-only. bit0 busy, bit1 err (sticky), bit2 timeout (sticky), bit3 overrun (sticky), others 0.
- 7: reads 0, writes ignored.

Reset values:
- ADDR=0, RDBUF=0, CTRL.inc=INC_RST, all status bits 0.
- wb_cyc_o=wb_stb_o=wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0, h_busy=0.

FSM states: IDLE, BUS.

IDLE:
- Launch event on strobe cycle N: DATA write, DATA read, or CTRL write with bit7=1.
- On launch: wb_adr_o={ADDR[31:2],2'b00}, wb_sel_o=1<<ADDR[1:0], wb_we_o per type, wb_dat_o={4{h_din}}.
- If inc=1, ADDR<=ADDR+1 (32-bit, wraps FFFFFFFF→00000000).
- At N+1: cyc/stb/h_busy=1, state BUS, timeout counter=0.

BUS:
- Counter increments each cycle.
- On wb_ack_i at cycle M: reads latch the selected byte lane of wb_dat_i into RDBUF. At M+1: cyc/stb/we=0, sel=0, h_busy=0, state IDLE.
- On wb_err_i: same termination; err=1; reads set RDBUF=FF.
- ack and err in the same cycle: err wins.
- Counter reaching TIMEOUT-1 with no ack/err: terminate next cycle; err=1, timeout=1; reads set RDBUF=FF.
- While in BUS, any launch event or ADDR write is ignored (ADDR, CTRL.inc and RDBUF unchanged) and sets overrun=1.
- DATA read in BUS still returns current RDBUF.
- STATUS reads and CTRL bit6 clears are always honoured.
- CTRL bit6 clear coinciding with an err/timeout set in the same cycle: set wins.

Other rules:
- h_rd and h_wr asserted together: write only.
- h_rd with no side effect (regs 0–3, 5–7) changes nothing.
- Reset mid-transaction: next cycle cyc/stb=0 and all state at reset values; no partial completion reported.
- At most one transaction outstanding. Minimum turnaround: ack at M, new launch accepted at M+1.

Test Plan:
- Reset, then read all regs → ADDR0–3=00, CTRL=01, STATUS=00, reg7=00; wb_cyc_o=0.
- Write ADDR=00001002, DATA=A5, slave acks after 2 cycles → wb_adr_o=00001000, sel=0100, dat_o=A5A5A5A5, we=1; cyc high exactly 3 cycles; ADDR reads 00001003 afterward.
- ADDR=01000003, CTRL=80, slave returns 5A000000 → RDBUF=5A. DATA read returns 5A and launches read at 01000004 with sel=0001. ADDR ends at 01000005.
- ADDR=FFFFFFFF, DATA write with inc=1 → ADDR wraps to 00000000. With CTRL=00, repeat write → ADDR unchanged.
- TIMEOUT=8, slave never acks, read launched → cyc high 8 cycles then drops; STATUS=06, RDBUF=FF. CTRL write 40 → STATUS=00.
- Second DATA write while busy → ignored, STATUS bit3=1, only one WB cycle seen.
- wb_err_i and wb_ack_i same cycle on a read → err=1, RDBUF=FF.
- reset asserted mid-BUS → cyc=0 next cycle, ADDR=0.

Source files
------------

// File: rtl/wb_host_port.sv
`default_nettype none
//------------------------------------------------------------------------------
// wb_host_port - 8-bit strobed host register port acting as a 32-bit Wishbone master (rev 1.0)
//------------------------------------------------------------------------------
module wb_host_port #(
  parameter int TIMEOUT = 255,
  parameter bit INC_RST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  h_addr,
  input  logic [7:0]  h_din,
  output logic [7:0]  h_dout,
  input  logic        h_rd,
  input  logic        h_wr,
  output logic        h_busy,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BUS = 1'b1} state_t;

  state_t      state, state_nx;
  logic [31:0] addr;
  logic [7:0]  rdbuf;
  logic        inc, st_err, st_tout, st_ovr;
  logic [15:0] cnt;
  logic [1:0]  lane;

  // A simultaneous read and write strobe is treated as a write only.
  logic wr, rd, addr_wr, data_wr, data_rd, ctrl_wr, launch_req;
  assign wr         = h_wr;
  assign rd         = h_rd & ~h_wr;
  assign addr_wr    = wr & ~h_addr[2];
  assign data_wr    = wr & (h_addr == 3'd4);
  assign data_rd    = rd & (h_addr == 3'd4);
  assign ctrl_wr    = wr & (h_addr == 3'd5);
  assign launch_req = data_wr | data_rd | (ctrl_wr & h_din[7]);

  logic launch, finish, fail, tout_hit, overrun;

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    finish   = 1'b0;
    fail     = 1'b0;
    tout_hit = 1'b0;
    overrun  = 1'b0;
    case (state)
      IDLE: begin
        if (launch_req) begin
          launch   = 1'b1;
          state_nx = BUS;
        end
      end
      BUS: begin
        overrun = launch_req | addr_wr;
        if (wb_err_i) begin
          finish = 1'b1;
          fail   = 1'b1;
        end else if (wb_ack_i) begin
          finish = 1'b1;
        end else if (cnt == CNT_LAST) begin
          finish   = 1'b1;
          fail     = 1'b1;
          tout_hit = 1'b1;
        end
        if (finish) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  logic [7:0] lane_byte;
  assign lane_byte = wb_dat_i[{lane, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (reset) begin
      addr     <= 32'd0;
      rdbuf    <= 8'd0;
      inc      <= INC_RST;
      st_err   <= 1'b0;
      st_tout  <= 1'b0;
      st_ovr   <= 1'b0;
      cnt      <= 16'd0;
      lane     <= 2'd0;
      wb_adr_o <= 32'd0;
      wb_sel_o <= 4'd0;
      wb_dat_o <= 32'd0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
    end else begin
      if (state == IDLE && addr_wr) addr[{h_addr[1:0], 3'b000} +: 8] <= h_din;
      if (launch) begin
        wb_adr_o <= {addr[31:2], 2'b00};
        wb_sel_o <= 4'b0001 << addr[1:0];
        wb_dat_o <= {4{h_din}};
        wb_we_o  <= data_wr;
        wb_cyc_o <= 1'b1;
        lane     <= addr[1:0];
        cnt      <= 16'd0;
        if (inc) addr <= addr + 32'd1;
      end
      // A launching CTRL write during a transaction is dropped whole, inc included.
      if (ctrl_wr && !(state == BUS && h_din[7])) inc <= h_din[0];
      if (state == BUS) begin
        cnt <= cnt + 16'd1;
        if (finish) begin
          wb_cyc_o <= 1'b0;
          wb_we_o  <= 1'b0;
          wb_sel_o <= 4'd0;
          if (!wb_we_o) rdbuf <= fail ? 8'hFF : lane_byte;
        end
      end
      if (ctrl_wr && h_din[6]) begin
        st_err  <= 1'b0;
        st_tout <= 1'b0;
        st_ovr  <= 1'b0;
      end
      if (fail)     st_err  <= 1'b1;
      if (tout_hit) st_tout <= 1'b1;
      if (overrun)  st_ovr  <= 1'b1;
    end
  end

  assign wb_stb_o = wb_cyc_o;
  assign h_busy   = wb_cyc_o;

  always_comb begin
    h_dout = 8'd0;
    case (h_addr)
      3'd0: h_dout = addr[7:0];
      3'd1: h_dout = addr[15:8];
      3'd2: h_dout = addr[23:16];
      3'd3: h_dout = addr[31:24];
      3'd4: h_dout = rdbuf;
      3'd5: h_dout = {7'd0, inc};
      3'd6: h_dout = {4'd0, st_ovr, st_tout, st_err, wb_cyc_o};
      default: h_dout = 8'd0;
    endcase
  end

endmodule
`default_nettype wire
